// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI register controller.
//   - state_t and ST_* constants: controller FSM encoding
//   - CMD_* constants: bit positions inside the command byte
package spi_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CMD    = 3'd1;
    localparam state_t ST_WDATA  = 3'd2;
    localparam state_t ST_RDATA  = 3'd3;
    localparam state_t ST_IGNORE = 3'd4;

    // Command byte: [7] 1=write/0=read, [6:ADDR_W] reserved, [ADDR_W-1:0] address
    localparam int unsigned CMD_WRITE_BIT = 7;
    localparam int unsigned CMD_RSV_MSB   = 6;

endpackage

// File: rtl/spi_cmd_decode.sv
// spi_cmd_decode: splits a received command byte into its fields.
// Ports:
//   rx_data  in   command byte
//   is_write out  1 = write command, 0 = read command
//   addr     out  start register address
//   rsv_err  out  1 when any reserved bit is set
module spi_cmd_decode
    import spi_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic [7:0]        rx_data,
    output logic              is_write,
    output logic [ADDR_W-1:0] addr,
    output logic              rsv_err
);

    logic [CMD_RSV_MSB:0] low_bits;

    always_comb begin
        low_bits = rx_data[CMD_RSV_MSB:0];
        is_write = rx_data[CMD_WRITE_BIT];
        addr     = rx_data[ADDR_W-1:0];
        // Shifting out the address leaves only the reserved field
        rsv_err  = |(low_bits >> ADDR_W);
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns an SPI byte stream into register read/write strobes.
// A frame is one ss-low interval; its first byte is a command, further bytes
// are write data (write) or clock-out slots (read).
// Build option: define SPI_REG_CTRL_AUTOINC_EN to auto-increment the address
// on every further data byte; otherwise only the first data byte acts.
// Ports:
//   clk, rst            clock, async active-high reset
//   ss                  slave select (active low, synchronised)
//   rx_data, rx_rdy     received byte and its one-cycle valid pulse
//   tx_data, tx_load    byte for the transmitter and its load pulse
//   wr_en/addr/data     register write strobe, address, data
//   rd_en/addr, rd_data register read strobe, address, combinational data
//   busy                FSM not idle
//   err                 pulse on rejected command
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int CMD_RSV_CHK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    output logic [7:0]        tx_data,
    output logic              tx_load,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output logic              err
);

    state_t            state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_load_q, tx_load_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              rd_en_q,   rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              err_q,     err_d;

    logic              cmd_is_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_rsv_err;

    spi_cmd_decode #(.ADDR_W(ADDR_W)) u_decode (
        .rx_data  (rx_data),
        .is_write (cmd_is_write),
        .addr     (cmd_addr),
        .rsv_err  (cmd_rsv_err)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        err_d     = 1'b0;
        // A read strobe always completes into tx_data one cycle later, even
        // if ss rises in between.
        tx_load_d = rd_en_q;
        tx_data_d = rd_en_q ? rd_data : tx_data_q;

        if (ss) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_CMD;
                ST_CMD: begin
                    if (rx_rdy) begin
                        if ((CMD_RSV_CHK != 0) && cmd_rsv_err) begin
                            state_d = ST_IGNORE;
                            err_d   = 1'b1;
                        end else if (cmd_is_write) begin
                            state_d = ST_WDATA;
                            addr_d  = cmd_addr;
                        end else begin
                            state_d   = ST_RDATA;
                            addr_d    = cmd_addr;
                            rd_en_d   = 1'b1;
                            rd_addr_d = cmd_addr;
                        end
                    end
                end
                ST_WDATA: begin
                    if (rx_rdy) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = rx_data;
`ifdef SPI_REG_CTRL_AUTOINC_EN
                        addr_d    = addr_q + ADDR_W'(1);
`else
                        state_d   = ST_IGNORE;
`endif
                    end
                end
                ST_RDATA: begin
                    if (rx_rdy) begin
`ifdef SPI_REG_CTRL_AUTOINC_EN
                        addr_d    = addr_q + ADDR_W'(1);
                        rd_en_d   = 1'b1;
                        rd_addr_d = addr_q + ADDR_W'(1);
`else
                        state_d   = ST_IGNORE;
`endif
                    end
                end
                ST_IGNORE: state_d = ST_IGNORE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            tx_data_q <= '0;
            tx_load_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tx_data_q <= tx_data_d;
            tx_load_q <= tx_load_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            err_q     <= err_d;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_load = tx_load_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign err     = err_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed self-checking bench for spi_reg_ctrl.
// Expectations for the auto-increment cases follow SPI_REG_CTRL_AUTOINC_EN.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       err;

    logic [7:0] regs [8];
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned wr_cnt   = 0;
    int unsigned rd_cnt   = 0;
    int unsigned err_cnt  = 0;
    int unsigned wr_base, rd_base, err_base;

    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];

    spi_reg_ctrl #(.ADDR_W(3), .CMD_RSV_CHK(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .ss      (ss),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .tx_data (tx_data),
        .tx_load (tx_load),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .err     (err)
    );

    // Strobe counters, sampled just after each active edge
    always @(posedge clk) begin
        #1;
        if (wr_en)  wr_cnt  = wr_cnt + 1;
        if (rd_en)  rd_cnt  = rd_cnt + 1;
        if (err)    err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drives one rx_rdy pulse; returns at the negedge after the sampling edge
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic snap;
        wr_base  = wr_cnt;
        rd_base  = rd_cnt;
        err_base = err_cnt;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 8'(8'h10 * i);
        regs[5] = 8'hC3;
        regs[6] = 8'h66;
        rst = 1'b1; ss = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0;
        idle_cycles(3);

        // Reset state
        check("rst_ctrl", {24'd0, tx_data, tx_load, wr_en, rd_en, err, busy} >> 0,
              32'd0);
        check("rst_addr", {18'd0, wr_addr, rd_addr, wr_data}, 32'd0);
        rst = 1'b0;
        idle_cycles(2);

        // Write 8'h5A to register 3
        snap();
        ss = 1'b0;
        send_byte(8'h83);
        check("wr_busy", 32'(busy), 32'd1);
        send_byte(8'h5A);
        check("wr_en", 32'(wr_en), 32'd1);
        check("wr_addr", 32'(wr_addr), 32'd3);
        check("wr_data", 32'(wr_data), 32'h5A);
        @(negedge clk);
        check("wr_en_pulse", 32'(wr_en), 32'd0);
        ss = 1'b1;
        @(negedge clk);
        check("wr_busy_end", 32'(busy), 32'd0);
        idle_cycles(2);
        check("wr_count", wr_cnt - wr_base, 32'd1);

        // Read register 5
        snap();
        ss = 1'b0;
        send_byte(8'h05);
        check("rd_en", 32'(rd_en), 32'd1);
        check("rd_addr", 32'(rd_addr), 32'd5);
        check("rd_tx_load_early", 32'(tx_load), 32'd0);
        @(negedge clk);
        check("rd_tx_load", 32'(tx_load), 32'd1);
        check("rd_tx_data", 32'(tx_data), 32'hC3);
        check("rd_en_pulse", 32'(rd_en), 32'd0);
        @(negedge clk);
        check("rd_tx_load_pulse", 32'(tx_load), 32'd0);
        // Master clocks the prefetched byte out
        send_byte(8'h00);
`ifdef SPI_REG_CTRL_AUTOINC_EN
        check("rd_next_en", 32'(rd_en), 32'd1);
        check("rd_next_addr", 32'(rd_addr), 32'd6);
        @(negedge clk);
        check("rd_next_data", 32'(tx_data), 32'h66);
`else
        check("rd_next_en", 32'(rd_en), 32'd0);
        @(negedge clk);
        check("rd_hold_data", 32'(tx_data), 32'hC3);
`endif
        ss = 1'b1;
        idle_cycles(2);
        check("rd_no_write", wr_cnt - wr_base, 32'd0);

        // Burst write starting at the top address
        snap();
        ss = 1'b0;
        send_byte(8'h87);
        send_byte(8'h11);
        check("burst1_en", 32'(wr_en), 32'd1);
        check("burst1_addr", 32'(wr_addr), 32'd7);
        check("burst1_data", 32'(wr_data), 32'h11);
        send_byte(8'h22);
`ifdef SPI_REG_CTRL_AUTOINC_EN
        check("burst2_en", 32'(wr_en), 32'd1);
        check("burst2_addr", 32'(wr_addr), 32'd0);
        check("burst2_data", 32'(wr_data), 32'h22);
        ss = 1'b1;
        idle_cycles(2);
        check("burst_count", wr_cnt - wr_base, 32'd2);
`else
        check("burst2_en", 32'(wr_en), 32'd0);
        check("burst2_data_hold", 32'(wr_data), 32'h11);
        ss = 1'b1;
        idle_cycles(2);
        check("burst_count", wr_cnt - wr_base, 32'd1);
`endif

        // Reserved bits set: rejected, rest of frame ignored
        snap();
        ss = 1'b0;
        send_byte(8'h48);
        check("rsv_err", 32'(err), 32'd1);
        @(negedge clk);
        check("rsv_err_pulse", 32'(err), 32'd0);
        send_byte(8'hFF);
        idle_cycles(2);
        check("rsv_no_strobe", (wr_cnt - wr_base) + (rd_cnt - rd_base), 32'd0);
        check("rsv_err_count", err_cnt - err_base, 32'd1);
        ss = 1'b1;
        idle_cycles(2);
        ss = 1'b0;
        send_byte(8'h81);
        send_byte(8'h01);
        check("rsv_recover_en", 32'(wr_en), 32'd1);
        check("rsv_recover_addr", 32'(wr_addr), 32'd1);
        check("rsv_recover_data", 32'(wr_data), 32'h01);
        ss = 1'b1;
        idle_cycles(2);

        // Reset between command and data byte
        ss = 1'b0;
        send_byte(8'h82);
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {23'd0, tx_data, tx_load, wr_en, rd_en, err, busy}, 32'd0);
        check("mid_rst_addr", {18'd0, wr_addr, rd_addr, wr_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        snap();
        // Treated as a command: 8'h5A has reserved bits set
        send_byte(8'h5A);
        check("mid_rst_no_wr", 32'(wr_en), 32'd0);
        check("mid_rst_err", 32'(err), 32'd1);
        ss = 1'b1;
        idle_cycles(3);
        check("mid_rst_wr_count", wr_cnt - wr_base, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, register address width (2**ADDR_W registers).
REQ-002 SHALL have parameter CMD_RSV_CHK, default 1, 1 = reject commands with nonzero reserved bits.
REQ-003 SHALL have port clk  in  1  system clock, all logic on posedge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ss  in  1  SPI slave select, active-low, pre-synchronised to clk.
REQ-006 SHALL have port rx_data  in  8  byte from SPI receiver, valid when rx_rdy=1.
REQ-007 SHALL have port rx_rdy  in  1  one-cycle pulse per received byte.
REQ-008 SHALL have port tx_data  out  8  byte for SPI transmitter, held until next tx_load.
REQ-009 SHALL have port tx_load  out  1  one-cycle pulse, tx_data newly valid.
REQ-010 SHALL have port wr_en  out  1  one-cycle register write strobe.
REQ-011 SHALL have port wr_addr  out  ADDR_W  write address, valid with wr_en.
REQ-012 SHALL have port wr_data  out  8  write data, valid with wr_en.
REQ-013 SHALL have port rd_en  out  1  one-cycle register read strobe.
REQ-014 SHALL have port rd_addr  out  ADDR_W  read address, valid with rd_en.
REQ-015 SHALL have port rd_data  in  8  register read data, combinational, same cycle as rd_en.
REQ-016 SHALL have port busy  out  1  high while state != IDLE.
REQ-017 SHALL have port err  out  1  one-cycle pulse on rejected command.

Function
REQ-018 Frame = ss low interval; first byte = command: bit7 1=write/0=read, bits6:ADDR_W reserved, bits ADDR_W-1:0 start address.
REQ-019 States: IDLE, CMD, WDATA, RDATA, IGNORE.
REQ-020 IDLE -> CMD when ss=0; any state -> IDLE when ss=1 (ss-high has priority over rx_rdy in the same cycle; that byte is discarded).
REQ-021 CMD + rx_rdy: write -> WDATA; read -> RDATA; reserved bits nonzero and CMD_RSV_CHK=1 -> IGNORE with err=1 next cycle.
REQ-022 Read command accepted at cycle N: rd_en/rd_addr at N+1, tx_data<=rd_data registered, tx_load=1 at N+2.
REQ-023 WDATA + rx_rdy at cycle N: wr_en, wr_addr, wr_data=rx_data at N+1.
REQ-024 RDATA + rx_rdy (master clocked out byte): address advance and prefetch per REQ-031/032, same N+1/N+2 timing as REQ-022.
REQ-025 IGNORE: all rx_rdy discarded; no strobes until ss=1.
REQ-026 Address arithmetic modulo 2**ADDR_W; max address wraps to 0.
REQ-027 wr_en, rd_en, tx_load, err never high in two consecutive cycles for one byte; at most one of wr_en/rd_en per cycle.
REQ-028 Frame ending with ss=1 before data byte: no write; pending tx_load still completes if already scheduled, no further strobes.

Reset
REQ-029 rst=1 forces state IDLE, address register 0, tx_data=8'h00, tx_load/wr_en/rd_en/err/busy=0, wr_addr/rd_addr/wr_data=0.
REQ-030 Reset mid-frame aborts the frame; after release, IDLE -> CMD requires ss=0 sampled; interrupted frame bytes ignored until a new command byte (next rx_rdy treated as command).

Configuration
REQ-031 With SPI_REG_CTRL_AUTOINC_EN defined: each further byte in WDATA writes to address+1; each rx_rdy in RDATA increments address and prefetches next register.
REQ-032 Without SPI_REG_CTRL_AUTOINC_EN: after first data byte, WDATA/RDATA go to IGNORE; extra bytes discarded, tx_data holds last value.

Structure
REQ-033 Shared package spi_pkg SHALL hold state enum, command bit positions, CMD_WRITE_BIT=7 constant.
REQ-034 Command decode SHALL be a sub-module spi_cmd_decode (rx_data -> is_write, addr, rsv_err); FSM and strobes stay in spi_reg_ctrl.

Verification
REQ-035 ss=0, bytes 8'h83,8'h5A, ss=1 -> wr_en one cycle after 2nd rx_rdy, wr_addr=3, wr_data=8'h5A; busy low after ss=1.
REQ-036 rd_data model reg[5]=8'hC3; ss=0, byte 8'h05 -> rd_addr=5 at N+1, tx_load at N+2 with tx_data=8'hC3.
REQ-037 AUTOINC_EN: ss=0, 8'h87,8'h11,8'h22 -> writes addr 7=8'h11 then addr 0=8'h22 (wrap).
REQ-038 No AUTOINC_EN: same stimulus -> single write addr 7=8'h11, third byte produces no strobe.
REQ-039 Command 8'h48 -> err pulse, following byte 8'hFF gives no wr_en/rd_en; ss=1 then 8'h81,8'h01 works normally.
REQ-040 rst asserted between command 8'h82 and data byte -> all outputs 0 immediately; post-reset data byte not written to addr 2.
